data_mem_ctrl: RTL and testbench

//   Parametrised data memory for the pipeline's MEM stage; successor to the single-cycle 16-bit data memory.

---
 rtl/data_mem_ctrl.sv | 155 +++++++++++++++
 tb/tb_data_mem_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// MEM-stage data memory with a valid/ready request handshake, narrow/wide accesses
// and address-range exceptions. One request is outstanding at a time.
module data_mem_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic                req_wide,
  input  logic [ADDR_W-1:0]   addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic                rsp_valid,
  output logic [2*DATA_W-1:0] rdata,
  output logic                exc,
  output logic [ADDR_W-1:0]   exc_addr
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthExt = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {StIdle, StLo, StHi, StErr} state_e;

  state_e              state_q, state_d;
  logic                write_q, wide_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0]   lo_q, lo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [2*DATA_W-1:0] rdata_q, rdata_d;
  logic                exc_q, exc_d;
  logic [ADDR_W-1:0]   exc_addr_q, exc_addr_d;

  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [IdxW-1:0]     mem_idx;
  logic                mem_we;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   rd_word;

  logic                accept;
  logic [ADDR_W:0]     addr_ext;
  logic                out_of_range;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid && req_ready;

  // One extra bit so addr+1 cannot wrap back to 0 and upper bits are never dropped.
  assign addr_ext     = {1'b0, addr};
  assign out_of_range = (addr_ext >= DepthExt) ||
                        (req_wide && ((addr_ext + (ADDR_W + 1)'(1)) >= DepthExt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      wide_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= req_write;
      wide_q  <= req_wide;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Array port: LO touches word[addr] (low half), HI touches word[addr+1] (high half).
  always_comb begin
    mem_idx   = addr_q[IdxW-1:0];
    mem_wdata = wdata_q[DATA_W-1:0];
    mem_we    = 1'b0;
    unique case (state_q)
      StLo: mem_we = write_q;
      StHi: begin
        mem_idx   = addr_q[IdxW-1:0] + IdxW'(1);
        mem_wdata = wdata_q[2*DATA_W-1:DATA_W];
        mem_we    = write_q;
      end
      default: ;
    endcase
  end

  assign rd_word = mem_q[mem_idx];

  // No reset on the array: contents survive rst_n.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_idx] <= mem_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    lo_d        = lo_q;
    rsp_valid_d = 1'b0;
    rdata_d     = '0;
    exc_d       = 1'b0;
    exc_addr_d  = exc_addr_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          state_d = out_of_range ? StErr : StLo;
        end
      end
      StLo: begin
        if (wide_q) begin
          state_d = StHi;
          lo_d    = write_q ? '0 : rd_word;
        end else begin
          state_d     = StIdle;
          rsp_valid_d = 1'b1;
          rdata_d     = write_q ? '0 : {{DATA_W{1'b0}}, rd_word};
        end
      end
      StHi: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rdata_d     = write_q ? '0 : {rd_word, lo_q};
      end
      StErr: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        exc_d       = 1'b1;
        exc_addr_d  = addr_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      lo_q        <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      exc_q       <= 1'b0;
      exc_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      exc_q       <= exc_d;
      exc_addr_q  <= exc_addr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign exc       = exc_q;
  assign exc_addr  = exc_addr_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: expected responses are queued at accept time
// and compared, including latency, when rsp_valid appears.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_wide = 1'b0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        exc;
  logic [15:0] exc_addr;

  data_mem_ctrl #(
    .DATA_W(16),
    .ADDR_W(16),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_wide (req_wide),
    .addr     (addr),
    .wdata    (wdata),
    .rsp_valid(rsp_valid),
    .rdata    (rdata),
    .exc      (exc),
    .exc_addr (exc_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rd;
    bit          ex;
    logic [15:0] ea;
    int          at;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_rsp at cycle %0d rdata=%h exc=%b", cyc, rdata, exc);
      end else begin
        mon_e = exp_q.pop_front();
        checks++;
        if (rdata !== mon_e.rd) begin
          errors++;
          $display("FAIL %s_rdata got %h want %h", mon_e.name, rdata, mon_e.rd);
        end
        checks++;
        if (exc !== mon_e.ex) begin
          errors++;
          $display("FAIL %s_exc got %b want %b", mon_e.name, exc, mon_e.ex);
        end
        if (mon_e.ex) begin
          checks++;
          if (exc_addr !== mon_e.ea) begin
            errors++;
            $display("FAIL %s_exc_addr got %h want %h", mon_e.name, exc_addr, mon_e.ea);
          end
        end
        checks++;
        if (cyc !== mon_e.at) begin
          errors++;
          $display("FAIL %s_latency got cycle %0d want %0d", mon_e.name, cyc, mon_e.at);
        end
      end
    end
  end

  task automatic push_exp(input bit wide, input logic [31:0] erd, input bit eex,
                          input logic [15:0] a, input string name);
    exp_t e;
    e.rd   = erd;
    e.ex   = eex;
    e.ea   = a;
    e.at   = cyc + ((wide && !eex) ? 2 : 1);
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending %0d want 0", name, exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rdata !== 32'h0 || exc !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle got rsp=%b rdata=%h exc=%b want 0 0 0", name, rsp_valid, rdata, exc);
    end
  endtask

  task automatic issue(input bit w, input bit wide, input logic [15:0] a, input logic [31:0] d,
                       input logic [31:0] erd, input bit eex, input string name);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_wide  = wide;
    addr      = a;
    wdata     = d;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_ready_pre got %b want 1", name, req_ready);
    end
    @(posedge clk);
    #1;
    push_exp(wide, erd, eex, a, name);
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s_ready_post got %b want 0", name, req_ready);
    end
    drain(name);
  endtask

  task automatic test_reset();
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || exc !== 1'b0 ||
        rdata !== 32'h0 || exc_addr !== 16'h0) begin
      errors++;
      $display("FAIL reset got ready=%b rsp=%b exc=%b rdata=%h exc_addr=%h want 1 0 0 0 0",
               req_ready, rsp_valid, exc, rdata, exc_addr);
    end
  endtask

  task automatic test_narrow();
    issue(1'b1, 1'b0, 16'h0001, 32'h0000_A05F, 32'h0, 1'b0, "wr1");
    issue(1'b0, 1'b0, 16'h0001, 32'h0, 32'h0000_A05F, 1'b0, "rd1");
    issue(1'b0, 1'b0, 16'h0002, 32'h0, 32'h0, 1'b0, "rd2_blank");
    issue(1'b1, 1'b0, 16'h0002, 32'hFFFF_030F, 32'h0, 1'b0, "wr2");
    issue(1'b0, 1'b0, 16'h0002, 32'h0, 32'h0000_030F, 1'b0, "rd2");
  endtask

  task automatic test_wide();
    issue(1'b1, 1'b1, 16'h0010, 32'h1234_5678, 32'h0, 1'b0, "wwr");
    issue(1'b0, 1'b0, 16'h0010, 32'h0, 32'h0000_5678, 1'b0, "wrd_lo");
    issue(1'b0, 1'b0, 16'h0011, 32'h0, 32'h0000_1234, 1'b0, "wrd_hi");
    issue(1'b0, 1'b1, 16'h0010, 32'h0, 32'h1234_5678, 1'b0, "wrd");
    issue(1'b1, 1'b1, 16'(DEPTH - 2), 32'hAAAA_BBBB, 32'h0, 1'b0, "wwr_top");
    issue(1'b0, 1'b1, 16'(DEPTH - 2), 32'h0, 32'hAAAA_BBBB, 1'b0, "wrd_top");
  endtask

  task automatic test_exceptions();
    issue(1'b0, 1'b0, 16'h5F01, 32'h0, 32'h0, 1'b1, "exc_rd");
    issue(1'b1, 1'b0, 16'(DEPTH - 1), 32'h0000_1111, 32'h0, 1'b0, "wr_last");
    issue(1'b1, 1'b1, 16'(DEPTH - 1), 32'h9999_7777, 32'h0, 1'b1, "exc_wwr");
    issue(1'b0, 1'b0, 16'(DEPTH - 1), 32'h0, 32'h0000_1111, 1'b0, "rd_last");
    issue(1'b1, 1'b0, 16'(DEPTH), 32'h0000_4444, 32'h0, 1'b1, "exc_depth");
    issue(1'b0, 1'b1, 16'hFFFF, 32'h0, 32'h0, 1'b1, "exc_wrap");
    issue(1'b0, 1'b0, 16'h0000, 32'h0, 32'h0000_0000, 1'b0, "rd_zero");
    checks++;
    if (exc_addr !== 16'hFFFF) begin
      errors++;
      $display("FAIL exc_addr_hold got %h want ffff", exc_addr);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wide  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      addr  = 16'h0020 + 16'(i);
      wdata = 32'h0000_C000 + 32'(i);
      @(posedge clk);
      #1;
      push_exp(1'b0, 32'h0, 1'b0, addr, "b2b_wr");
      checks++;
      if (req_ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_ready_low got %b want 0", req_ready);
      end
      if (i < 2) begin
        @(posedge clk);
        #1;
      end
    end
    req_valid = 1'b0;
    drain("b2b");
    for (int i = 0; i < 3; i++) begin
      issue(1'b0, 1'b0, 16'h0020 + 16'(i), 32'h0, 32'h0000_C000 + 32'(i), 1'b0, "b2b_rd");
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_wide  = 1'b1;
    addr      = 16'h0030;
    wdata     = 32'hBEEF_CAFE;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got ready=%b rsp=%b want 1 0", req_ready, rsp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready got %b want 1", req_ready);
    end
    issue(1'b0, 1'b0, 16'h0030, 32'h0, 32'h0000_CAFE, 1'b0, "rst_lo");
    issue(1'b0, 1'b0, 16'h0031, 32'h0, 32'h0000_0000, 1'b0, "rst_hi");
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_narrow();
    test_wide();
    test_exceptions();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached time %0t", $time);
    $fatal(1);
  end

endmodule
